// File: rtl/sim_device_responder_if.sv
// Serial link and decoded-command bundle between the simulator-side responder and the car side.
interface sim_device_responder_if;
  logic       rx;
  logic       tx;
  logic [3:0] detector_in;
  logic [3:0] moving_state_out;
  logic       place_beacon_pulse;
  logic       destroy_beacon_pulse;
  logic       frame_valid;
  logic       hdr_err;
  logic       frame_err;
  logic       tx_busy;
  logic       link_lost;

  modport slave (
    input  rx, detector_in,
    output tx, moving_state_out, place_beacon_pulse, destroy_beacon_pulse,
           frame_valid, hdr_err, frame_err, tx_busy, link_lost
  );

  modport master (
    output rx, detector_in,
    input  tx, moving_state_out, place_beacon_pulse, destroy_beacon_pulse,
           frame_valid, hdr_err, frame_err, tx_busy, link_lost
  );
endinterface

// File: rtl/sim_device_responder.sv
// 8N1 far-end responder: decodes car command frames and answers each with a detector status byte.
// Optional link watchdog enabled by defining SIM_DEVICE_WATCHDOG_EN.
module sim_device_responder #(
  parameter int unsigned CLKS_PER_BIT   = 10416,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input logic                   sys_clk,
  input logic                   rst,
  sim_device_responder_if.slave bus
);
  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("sim_device_responder: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {RIdle, RStart, RData, RStop, RWaitHigh} rx_state_e;
  typedef enum logic [1:0] {TIdle, TStart, TData, TStop} tx_state_e;

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            accept, hdr_bad, stop_bad;
  logic            fv_q, place_q, destroy_q, hdr_err_q, frame_err_q;
  logic [3:0]      ms_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    accept     = 1'b0;
    hdr_bad    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      RIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RStart;
      end
      RStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RIdle : RData;
      end
      RData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d  = '0;
        rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
        rx_bit_d  = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RStop;
      end
      RStop: if (rx_cnt_q == BitLast) begin
        rx_cnt_d = '0;
        if (!rx_sync_q) begin
          stop_bad   = 1'b1;
          rx_state_d = RWaitHigh;
        end else begin
          rx_state_d = RIdle;
          accept     = (rx_byte_q[7:6] == 2'b10);
          hdr_bad    = (rx_byte_q[7:6] != 2'b10);
        end
      end
      RWaitHigh: begin
        // A broken frame leaves the line low; resync only once it idles high.
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RIdle;
      end
      default: rx_state_d = RIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_state_q  <= RIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      fv_q        <= 1'b0;
      place_q     <= 1'b0;
      destroy_q   <= 1'b0;
      hdr_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      fv_q        <= accept;
      place_q     <= accept & rx_byte_q[4];
      destroy_q   <= accept & rx_byte_q[5];
      hdr_err_q   <= hdr_bad;
      frame_err_q <= stop_bad;
    end
  end

`ifdef SIM_DEVICE_WATCHDOG_EN
  localparam int unsigned    WdW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES);

  logic [WdW-1:0] wd_cnt_q;
  logic           link_lost_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ms_q        <= '0;
      wd_cnt_q    <= '0;
      link_lost_q <= 1'b0;
    end else if (accept) begin
      ms_q        <= rx_byte_q[3:0];
      wd_cnt_q    <= '0;
      link_lost_q <= 1'b0;
    end else if (wd_cnt_q == WdMax - 1'b1) begin
      wd_cnt_q    <= WdMax;
      ms_q        <= '0;
      link_lost_q <= 1'b1;
    end else if (wd_cnt_q != WdMax) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign bus.link_lost = link_lost_q;
`else
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ms_q <= '0;
    end else if (accept) begin
      ms_q <= rx_byte_q[3:0];
    end
  end

  assign bus.link_lost = 1'b0;
`endif

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            pending_q, pending_d;
  logic            tx_q, tx_d, busy_q;
  logic            tx_start;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      TIdle: begin
        tx_cnt_d = '0;
        tx_start = fv_q;
      end
      TStart: if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TData;
      end
      TData: if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = TStop;
      end
      TStop: if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_start   = pending_q | fv_q;
        tx_state_d = TIdle;
      end
      default: tx_state_d = TIdle;
    endcase
    // Detector values are captured only at the moment a byte is launched.
    if (tx_start) begin
      tx_state_d = TStart;
      tx_cnt_d   = '0;
      tx_shift_d = {4'b0000, bus.detector_in};
    end
    pending_d = pending_q;
    if (fv_q && tx_state_q != TIdle) pending_d = 1'b1;
    if (tx_start) pending_d = 1'b0;
    case (tx_state_d)
      TStart:  tx_d = 1'b0;
      TData:   tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_state_q <= TIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      pending_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      pending_q  <= pending_d;
      tx_q       <= tx_d;
      busy_q     <= (tx_state_d != TIdle);
    end
  end

  assign bus.tx                   = tx_q;
  assign bus.tx_busy              = busy_q;
  assign bus.moving_state_out     = ms_q;
  assign bus.frame_valid          = fv_q;
  assign bus.place_beacon_pulse   = place_q;
  assign bus.destroy_beacon_pulse = destroy_q;
  assign bus.hdr_err              = hdr_err_q;
  assign bus.frame_err            = frame_err_q;
endmodule
